// File: rtl/exec_hazard_controller.sv
// Execute-stage hazard unit: shadows EX/MEM/WB destination info to drive operand
// forwarding selects, load-use stalls and post-branch flush sequencing.
module exec_hazard_controller #(
    parameter int REG_BITS     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_src1,
    input  logic [REG_BITS-1:0] id_src2,
    input  logic                id_use1,
    input  logic                id_use2,
    input  logic [REG_BITS-1:0] id_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                ex_branch_taken,
    output logic [1:0]          Forward1Sel,
    output logic [1:0]          Forward2Sel,
    output logic                stall_pc,
    output logic                stall_ifid,
    output logic                flush_ifid,
    output logic                flush_idex,
    output logic [15:0]         stall_count
);

    typedef struct packed {
        logic                v;
        logic [REG_BITS-1:0] src1;
        logic [REG_BITS-1:0] src2;
        logic                use1;
        logic                use2;
        logic [REG_BITS-1:0] dst;
        logic                wr;
        logic                ld;
    } ex_slot_t;

    typedef struct packed {
        logic                v;
        logic [REG_BITS-1:0] dst;
        logic                wr;
        logic                ld;
    } mem_slot_t;

    typedef struct packed {
        logic                v;
        logic [REG_BITS-1:0] dst;
        logic                wr;
    } wb_slot_t;

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    ex_slot_t    ex_slot;
    mem_slot_t   mem_slot;
    wb_slot_t    wb_slot;
    state_t      state, state_next;
    logic [1:0]  flush_cnt, flush_cnt_next;
    logic [15:0] stall_cnt;
    logic        hazard;

    function automatic logic hit(input logic v, input logic wr,
                                 input logic [REG_BITS-1:0] dst,
                                 input logic [REG_BITS-1:0] r);
        return v & wr & (dst == r);
    endfunction

    // A load still in MEM has no data yet, so it may only forward from WB.
    function automatic logic [1:0] fwd_sel(input logic use_op,
                                           input logic [REG_BITS-1:0] src);
        if (use_op && hit(mem_slot.v, mem_slot.wr, mem_slot.dst, src) && !mem_slot.ld)
            return 2'b01;
        else if (use_op && hit(wb_slot.v, wb_slot.wr, wb_slot.dst, src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic load_hit(input logic [REG_BITS-1:0] r);
        return (hit(ex_slot.v, ex_slot.wr, ex_slot.dst, r) & ex_slot.ld) |
               (hit(mem_slot.v, mem_slot.wr, mem_slot.dst, r) & mem_slot.ld);
    endfunction

    assign Forward1Sel = fwd_sel(ex_slot.use1, ex_slot.src1);
    assign Forward2Sel = fwd_sel(ex_slot.use2, ex_slot.src2);
    assign hazard      = id_valid & ((id_use1 & load_hit(id_src1)) |
                                     (id_use2 & load_hit(id_src2)));
    assign stall_count = stall_cnt;

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        stall_pc       = 1'b0;
        stall_ifid     = 1'b0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        case (state)
            RUN: begin
                if (ex_slot.v && ex_branch_taken) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_next = FLUSH_LOAD;
                        state_next     = FLUSH;
                    end
                end else if (hazard) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            FLUSH: begin
                flush_ifid     = 1'b1;
                flush_idex     = 1'b1;
                flush_cnt_next = flush_cnt - 2'd1;
                if (flush_cnt <= 2'd1)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot   <= '0;
            mem_slot  <= '0;
            wb_slot   <= '0;
            state     <= RUN;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            wb_slot  <= '{v: mem_slot.v, dst: mem_slot.dst, wr: mem_slot.wr};
            mem_slot <= '{v: ex_slot.v, dst: ex_slot.dst, wr: ex_slot.wr, ld: ex_slot.ld};
            if (flush_idex)
                ex_slot <= '0;
            else
                ex_slot <= '{v: id_valid, src1: id_src1, src2: id_src2,
                             use1: id_use1, use2: id_use2, dst: id_dst,
                             wr: id_reg_write, ld: id_mem_read};
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (stall_pc && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
